// File: rtl/touch_adc_avg.sv
// ADS7843-style touch ADC controller: debounced pen detect, 2^N_AVG_LOG2-sample
// averaging per axis, abort on pen release, 8/12-bit conversions.
module touch_adc_avg #(
  parameter int CLK_DIV      = 25,
  parameter int N_AVG_LOG2   = 2,
  parameter int MODE_8BIT    = 0,
  parameter int RES          = 12,
  parameter int IDLE_GAP     = 4,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic           CLK,
  input  logic           RST_n,
  input  logic           ADC_PENIRQ_n,
  input  logic           ADC_BUSY,
  input  logic           ADC_DOUT,
  output logic           ADC_DCLK,
  output logic           SCEN,
  output logic           ADC_DIN,
  output logic [RES-1:0] X_COORD,
  output logic [RES-1:0] Y_COORD,
  output logic           COORD_VALID,
  output logic           PEN_DOWN,
  output logic [1:0]     DBG_STATE,
  output logic           DBG_BUSY
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int ACC_W = RES + N_AVG_LOG2;
  localparam int FC_W  = N_AVG_LOG2 + 1;
  localparam logic [7:0] CMD_X = (MODE_8BIT != 0) ? 8'h98 : 8'h90;
  localparam logic [7:0] CMD_Y = (MODE_8BIT != 0) ? 8'hD8 : 8'hD0;
  localparam logic [4:0] LAST_SAMPLE = 5'(8 + RES);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP, S_PUBLISH} state_t;

  state_t           r_state;
  logic             r_pen_s1, r_pen_s2, r_busy_s1, r_busy_s2;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_pen_down;
  logic             r_scen, r_dclk, r_din, r_half, r_valid;
  logic [DIV_W-1:0] r_div;
  logic [4:0]       r_period;
  logic [GAP_W-1:0] r_gap;
  logic [FC_W-1:0]  r_frame_cnt;
  logic [RES-1:0]   r_shift, r_x, r_y;
  logic [ACC_W-1:0] r_acc_x, r_acc_y;

  logic [7:0] w_cmd;
  logic [4:0] w_next_period;
  logic       w_din_next;
  logic       w_sample;

  // Top bit of the frame counter selects the axis: first half X, second half Y.
  assign w_cmd         = r_frame_cnt[N_AVG_LOG2] ? CMD_Y : CMD_X;
  assign w_next_period = r_period + 5'd1;
  assign w_sample      = (r_period >= 5'd9) && (r_period <= LAST_SAMPLE);

  always_comb begin
    w_din_next = 1'b0;
    if (w_next_period < 5'd8) w_din_next = w_cmd[3'd7 - w_next_period[2:0]];
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_pen_s1  <= 1'b1;
      r_pen_s2  <= 1'b1;
      r_busy_s1 <= 1'b0;
      r_busy_s2 <= 1'b0;
    end else begin
      r_pen_s1  <= ADC_PENIRQ_n;
      r_pen_s2  <= r_pen_s1;
      r_busy_s1 <= ADC_BUSY;
      r_busy_s2 <= r_busy_s1;
    end
  end

  // PENIRQ is meaningless during a conversion, so release is only honoured in IDLE/GAP.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_deb_cnt  <= '0;
      r_pen_down <= 1'b0;
    end else if (!r_pen_down) begin
      if (!r_pen_s2) begin
        if (r_deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
          r_pen_down <= 1'b1;
          r_deb_cnt  <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end else if (r_pen_s2 && (r_state == S_IDLE || r_state == S_GAP)) begin
      r_pen_down <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= S_IDLE;
      r_scen      <= 1'b1;
      r_dclk      <= 1'b0;
      r_din       <= 1'b0;
      r_half      <= 1'b0;
      r_div       <= '0;
      r_period    <= '0;
      r_gap       <= '0;
      r_frame_cnt <= '0;
      r_shift     <= '0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pen_down) begin
            r_state <= S_FRAME;
            r_scen  <= 1'b0;
            r_din   <= w_cmd[7];
          end
        end
        S_FRAME: begin
          if (r_div != DIV_W'(CLK_DIV - 1)) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div <= '0;
            if (!r_half) begin
              r_half <= 1'b1;
              r_dclk <= 1'b1;
              if (w_sample) r_shift <= {r_shift[RES-2:0], ADC_DOUT};
            end else begin
              r_half <= 1'b0;
              r_dclk <= 1'b0;
              if (r_period == 5'd23) begin
                r_scen      <= 1'b1;
                r_din       <= 1'b0;
                r_period    <= '0;
                r_gap       <= '0;
                r_frame_cnt <= r_frame_cnt + FC_W'(1);
                if (r_frame_cnt[N_AVG_LOG2]) r_acc_y <= r_acc_y + ACC_W'(r_shift);
                else                         r_acc_x <= r_acc_x + ACC_W'(r_shift);
                r_state     <= S_GAP;
              end else begin
                r_period <= w_next_period;
                r_din    <= w_din_next;
              end
            end
          end
        end
        S_GAP: begin
          // A wrapped frame counter means the last Y frame just finished.
          if (r_frame_cnt != '0 && !r_pen_down) begin
            r_acc_x     <= '0;
            r_acc_y     <= '0;
            r_frame_cnt <= '0;
            r_state     <= S_IDLE;
          end else if (r_gap == GAP_W'(IDLE_GAP - 1)) begin
            if (r_frame_cnt == '0) begin
              r_state <= S_PUBLISH;
            end else begin
              r_state <= S_FRAME;
              r_scen  <= 1'b0;
              r_din   <= w_cmd[7];
            end
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        S_PUBLISH: begin
          r_x     <= RES'(r_acc_x >> N_AVG_LOG2);
          r_y     <= RES'(r_acc_y >> N_AVG_LOG2);
          r_valid <= 1'b1;
          r_acc_x <= '0;
          r_acc_y <= '0;
          if (r_pen_down) begin
            r_state <= S_FRAME;
            r_scen  <= 1'b0;
            r_din   <= w_cmd[7];
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ADC_DCLK    = r_dclk;
  assign SCEN        = r_scen;
  assign ADC_DIN     = r_din;
  assign X_COORD     = r_x;
  assign Y_COORD     = r_y;
  assign COORD_VALID = r_valid;
  assign PEN_DOWN    = r_pen_down;
  assign DBG_STATE   = r_state;
  assign DBG_BUSY    = r_busy_s2;

endmodule

// File: doc/touch_adc_avg.md
# touch_adc_avg

Parametrised successor to the touch-panel ADC controller. Drives an ADS7843-compatible serial touch ADC, acquires 2^N_AVG_LOG2 samples per axis, and publishes the averaged X/Y coordinates with a one-cycle valid strobe. It also provides debounced pen detection, abort-on-release and selectable 8/12-bit resolution. It sits between the ADC pins and the coordinate consumers (7-segment decoder, future UI logic).

## Interface
- CLK_DIV, 25: system clocks per DCLK half-period (≥1); DCLK period = 2·CLK_DIV.
- N_AVG_LOG2, 2: log2 of samples averaged per axis (0..4).
- MODE_8BIT, 0: 0 = 12-bit conversions, 1 = 8-bit.
- RES, 12: coordinate width, must equal 12 when MODE_8BIT=0 and 8 when MODE_8BIT=1.
- IDLE_GAP, 4: clocks with SCEN high between frames (≥1).
- DEBOUNCE_CYC, 1000: consecutive synchronised pen-low clocks required to declare pen down.
- CLK  in  1  system clock; single clock domain.
- RST_n  in  1  asynchronous, active-low reset.
- ADC_PENIRQ_n  in  1  pen interrupt, active low, asynchronous (2-FF synchronised).
- ADC_BUSY  in  1  ADC busy; synchronised, not used for timing (reserved).
- ADC_DOUT  in  1  ADC serial data, MSB first.
- ADC_DCLK  out  1  serial clock, idle low.
- SCEN  out  1  ADC chip select, active low.
- ADC_DIN  out  1  command bit to ADC.
- X_COORD  out  RES  averaged X.
- Y_COORD  out  RES  averaged Y.
- COORD_VALID  out  1  one-cycle strobe when X/Y update.
- PEN_DOWN  out  1  debounced pen state.

## Operation
- Reset values: ADC_DCLK=0, SCEN=1, ADC_DIN=0, X_COORD=0, Y_COORD=0, COORD_VALID=0, PEN_DOWN=0; FSM in IDLE, accumulators and counters cleared.
- Debounce: PEN_DOWN sets after DEBOUNCE_CYC consecutive synchronised lows. It clears on the first synchronised high sampled while in IDLE or GAP. The pen is not sampled during FRAME, because PENIRQ is invalid during conversion.
- Commands are S A2 A1 A0 MODE SER/DFR PD1 PD0: X = 0x90 (0x98 with 8-bit mode), Y = 0xD0 (0xD8 with 8-bit mode). PD=00 keeps PENIRQ enabled between conversions.
- FSM states:
  - IDLE: waits for PEN_DOWN, then goes to FRAME.
  - FRAME: one 24-period conversion; on completion goes to GAP.
  - GAP: IDLE_GAP clocks with SCEN high; then PUBLISH, FRAME or IDLE.
  - PUBLISH: one clock.
- Sequence: 2^N_AVG_LOG2 X frames, then 2^N_AVG_LOG2 Y frames. After the last Y frame's GAP, the FSM enters PUBLISH.
- PUBLISH writes X_COORD = accX >> N_AVG_LOG2 and Y_COORD = accY >> N_AVG_LOG2 (truncating), pulses COORD_VALID and clears the accumulators. If PEN_DOWN is still set it starts a new sequence; otherwise it goes to IDLE.
- Accumulators are RES+N_AVG_LOG2 bits wide, so they cannot overflow.
- Pen release: if PEN_DOWN clears in a GAP mid-sequence, the FSM discards the partial accumulation, goes to IDLE, does not pulse COORD_VALID, and leaves X_COORD/Y_COORD unchanged.
- The running frame is always completed; SCEN never rises mid-frame except on reset.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); the ADC sees SCEN rise and aborts.

## Timing
- A frame is 24 DCLK periods, k=0..23. Each period is a low half of CLK_DIV clocks followed by a high half of CLK_DIV clocks.
- SCEN falls at the start of period 0's low half and rises together with the DCLK fall that ends period 23. SCEN is low for exactly 48·CLK_DIV clocks.
- ADC_DIN is updated at the start of each low half: bit 7-k of the command for k=0..7, and 0 for k≥8.
- ADC_DOUT is sampled on the CLK edge on which DCLK rises, for k=9..20 in 12-bit mode or k=9..16 in 8-bit mode, shifted MSB first. Other periods are ignored.
- Frame cost = 48·CLK_DIV + IDLE_GAP clocks.
- Latency from FRAME entry to the COORD_VALID strobe = 2·2^N_AVG_LOG2·(48·CLK_DIV + IDLE_GAP) + 1 clocks.
- X_COORD/Y_COORD change only in the COORD_VALID cycle and hold otherwise.
- Pen-down to first SCEN fall = 2 (sync) + DEBOUNCE_CYC + 1 clocks.

## Test plan
Common parameters: CLK_DIV=2, N_AVG_LOG2=2, IDLE_GAP=4, DEBOUNCE_CYC=8, 12-bit mode.
- Reset/idle: hold RST_n=0, then release with PENIRQ_n=1 for 1000 clocks -> SCEN=1, DCLK=0, DIN=0, outputs 0, no COORD_VALID.
- Command/framing: pen down -> SCEN low for 96 clocks; DIN carries 0x90 on the first four frames and 0xD0 on the next four; 24 DCLK rises per frame.
- Averaging: ADC model returns X samples 100,101,102,103 and Y samples 4095 ×4 -> single COORD_VALID with X_COORD=101 and Y_COORD=4095, 801 clocks after the first FRAME entry.
- Glitch rejection: PENIRQ_n low pulse of 5 clocks -> PEN_DOWN stays 0, no frames.
- Abort: pen released during the third X frame -> frame finishes, FSM returns to IDLE in the following GAP, no COORD_VALID, previous coordinates retained.
- 8-bit mode (MODE_8BIT=1, RES=8): DIN shows 0x98/0xD8, 8 bits captured, a 0xAB pattern yields X_COORD=0xAB; async reset asserted mid-frame -> SCEN=1 and DCLK=0 within the same cycle.
